// File: rtl/fp_to_q230.sv
// fp_to_q230: multicycle IEEE-754 single to Q2.30 converter with start/done handshake.
module fp_to_q230 #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, DECODE, SHIFT, FINISH} state_t;
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  state_t state, state_n;
  logic s, sat;
  logic [7:0] e;
  logic [31:0] mag;
  logic [4:0] r, k;
  logic [7:0] rd;
  assign rd = 8'd120 - e;
  assign k = r < STEP ? r : STEP;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? DECODE : IDLE;
      DECODE:  state_n = (e != 8'd0 && e < 8'd120) ? SHIFT : FINISH;
      SHIFT:   state_n = r <= STEP ? FINISH : SHIFT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      s      <= 1'b0;
      e      <= '0;
      mag    <= '0;
      r      <= '0;
      sat    <= 1'b0;
    end else if (clk_en) begin
      state <= state_n;
      done  <= state == FINISH;
      case (state)
        IDLE: if (start) begin
          s   <= dataa[31];
          e   <= dataa[30:23];
          mag <= {8'b0, 1'b1, dataa[22:0]};
        end
        DECODE: begin
          sat <= e[7];
          // saturated magnitudes are stored so that the FINISH negation leaves them intact
          if (e == 8'd0) mag <= '0;
          else if (e[7]) mag <= s ? 32'h8000_0000 : 32'h7FFF_FFFF;
          else if (e >= 8'd120) mag <= mag << e[2:0];
          else r <= e < 8'd96 ? 5'd24 : rd[4:0];
        end
        SHIFT: begin
          mag <= mag >> k;
          r   <= r - k;
        end
        default: begin
          result <= s ? -mag : mag;
          ovf    <= sat;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_to_q230.sv
// tb_fp_to_q230: directed vectors for fp_to_q230 with hand-computed Q2.30 results and latencies.
module tb_fp_to_q230;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1, start = 1'b0, done, ovf;
  logic [31:0] dataa = '0, result;
  int checks = 0, failures = 0;
  fp_to_q230 #(.SHIFT_STEP(4)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .done(done), .result(result), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] er,
                     input logic eo, input int el);
    int n;
    start = 1'b1;
    dataa = a;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_lat"}, n, el);
    chk({tag, "_res"}, result, er);
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_res", result, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run("one",     32'h3F80_0000, 32'h4000_0000, 0, 2);
    run("mone",    32'hBF80_0000, 32'hC000_0000, 0, 2);
    run("half",    32'h3F00_0000, 32'h2000_0000, 0, 2);
    run("m175",    32'hBFE0_0000, 32'h9000_0000, 0, 2);
    run("pi4",     32'h3F49_0FDB, 32'h3243_F6C0, 0, 2);
    run("max",     32'h3FFF_FFFF, 32'h7FFF_FF80, 0, 2);
    run("p2m30",   32'h3080_0000, 32'h0000_0001, 0, 8);
    run("m2m30",   32'hB080_0000, 32'hFFFF_FFFF, 0, 8);
    run("p2m31",   32'h3000_0000, 32'h0000_0000, 0, 8);
    run("p2m24",   32'h3380_0000, 32'h0000_0040, 0, 7);
    run("p2m11",   32'h3A00_0000, 32'h0008_0000, 0, 3);
    run("trunc",   32'hBA00_0001, 32'hFFF8_0000, 0, 3);
    run("zero",    32'h0000_0000, 32'h0000_0000, 0, 2);
    run("nzero",   32'h8000_0000, 32'h0000_0000, 0, 2);
    run("denorm",  32'h0000_0001, 32'h0000_0000, 0, 2);
    run("two",     32'h4000_0000, 32'h7FFF_FFFF, 1, 2);
    run("ninf",    32'hFF80_0000, 32'h8000_0000, 1, 2);
    run("nan",     32'h7FC0_0000, 32'h7FFF_FFFF, 1, 2);
    run("ok_after", 32'h3F80_0000, 32'h4000_0000, 0, 2);
    // clk_en stall mid-SHIFT with ignored start pulses
    start = 1'b1;
    dataa = 32'h3080_0000;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1 n++;
      if (n == 3) begin
        clk_en = 1'b0;
        start = 1'b1;
        dataa = 32'h4000_0000;
      end
      if (n == 6) clk_en = 1'b1;
      if (n == 7) start = 1'b0;
    end
    chk("stall_lat", n, 11);
    chk("stall_res", result, 32'h0000_0001);
    chk("stall_ovf", {31'b0, ovf}, 0);
    clk_en = 1'b0;
    @(posedge clk);
    #1;
    chk("frozen_done", {31'b0, done}, 1);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("unfrozen_done", {31'b0, done}, 0);
    run("pre_rst", 32'hBF80_0000, 32'hC000_0000, 0, 2);
    // reset during SHIFT aborts the operation
    start = 1'b1;
    dataa = 32'h3080_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_res", result, 0);
    chk("abort_ovf", {31'b0, ovf}, 0);
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (done) n++;
    end
    chk("abort_nodone", n, 0);
    run("post_rst", 32'h3F80_0000, 32'h4000_0000, 0, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
